// File: rtl/midi_rx.sv
// MIDI front end: 8N1 UART receiver feeding a channel-voice parser that emits
// note-on / note-off strobes with the note and velocity of the last event.
module midi_rx #(
    parameter int CLK_HZ  = 10_000_000,
    parameter int BAUD    = 31250,
    parameter int CHANNEL = 0,
    parameter bit OMNI    = 1'b0
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       rxData_i,
    output logic       noteOn_o,
    output logic       noteOff_o,
    output logic [6:0] note_o,
    output logic [6:0] velocity_o,
    output logic       frameErr_o
);
    localparam int BIT_CYC = CLK_HZ / BAUD;
    localparam int CW      = $clog2(BIT_CYC);
    localparam logic [CW-1:0] HALF_LD = CW'(BIT_CYC / 2 - 1);
    localparam logic [CW-1:0] FULL_LD = CW'(BIT_CYC - 1);
    localparam logic [3:0]    CH      = 4'(CHANNEL);

    typedef enum logic [2:0] {R_IDLE, R_START, R_DATA, R_STOP, R_WAITHI} rx_state_t;
    typedef enum logic [1:0] {P_IDLE, P_D1, P_D2} p_state_t;

    logic rx_meta, rx_s;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            rx_meta <= 1'b1;
            rx_s    <= 1'b1;
        end else begin
            rx_meta <= rxData_i;
            rx_s    <= rx_meta;
        end
    end

    rx_state_t     r_state, r_next;
    logic [CW-1:0] cnt, cnt_next;
    logic [2:0]    bit_cnt, bit_next;
    logic [7:0]    shreg, sh_next;
    logic          byte_vld, frame_bad;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state    <= R_IDLE;
            cnt        <= '0;
            bit_cnt    <= '0;
            shreg      <= '0;
            frameErr_o <= 1'b0;
        end else begin
            r_state    <= r_next;
            cnt        <= cnt_next;
            bit_cnt    <= bit_next;
            shreg      <= sh_next;
            frameErr_o <= frame_bad;
        end
    end

    always_comb begin
        r_next    = r_state;
        cnt_next  = cnt;
        bit_next  = bit_cnt;
        sh_next   = shreg;
        byte_vld  = 1'b0;
        frame_bad = 1'b0;
        case (r_state)
            R_IDLE: if (!rx_s) begin
                r_next   = R_START;
                bit_next = '0;
                cnt_next = HALF_LD;
            end
            R_START: begin
                if (cnt != '0)  cnt_next = cnt - 1'b1;
                else if (!rx_s) begin
                    r_next   = R_DATA;
                    cnt_next = FULL_LD;
                end else        r_next = R_IDLE;
            end
            R_DATA: begin
                if (cnt != '0) cnt_next = cnt - 1'b1;
                else begin
                    sh_next  = {rx_s, shreg[7:1]};
                    cnt_next = FULL_LD;
                    bit_next = bit_cnt + 3'd1;
                    if (bit_cnt == 3'd7) r_next = R_STOP;
                end
            end
            R_STOP: begin
                if (cnt != '0) cnt_next = cnt - 1'b1;
                else if (rx_s) begin
                    byte_vld = 1'b1;
                    r_next   = R_IDLE;
                end else begin
                    frame_bad = 1'b1;
                    r_next    = R_WAITHI;
                end
            end
            // a break / stuck-low line must go high before a new frame can start
            R_WAITHI: if (rx_s) r_next = R_IDLE;
            default:  r_next = R_IDLE;
        endcase
    end

    // Parser consumes the byte on the stop-sample edge, so strobes land one cycle later.
    p_state_t   p_state, p_next;
    logic       stat_nine, stat_nine_next;
    logic       len2, len2_next;
    logic       accept, accept_next;
    logic [6:0] note_hold, note_hold_next;
    logic       on_next, off_next;
    logic [6:0] note_out_next, vel_out_next;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            p_state    <= P_IDLE;
            stat_nine  <= 1'b0;
            len2       <= 1'b0;
            accept     <= 1'b0;
            note_hold  <= '0;
            noteOn_o   <= 1'b0;
            noteOff_o  <= 1'b0;
            note_o     <= '0;
            velocity_o <= '0;
        end else begin
            p_state    <= p_next;
            stat_nine  <= stat_nine_next;
            len2       <= len2_next;
            accept     <= accept_next;
            note_hold  <= note_hold_next;
            noteOn_o   <= on_next;
            noteOff_o  <= off_next;
            note_o     <= note_out_next;
            velocity_o <= vel_out_next;
        end
    end

    always_comb begin
        p_next         = p_state;
        stat_nine_next = stat_nine;
        len2_next      = len2;
        accept_next    = accept;
        note_hold_next = note_hold;
        on_next        = 1'b0;
        off_next       = 1'b0;
        note_out_next  = note_o;
        vel_out_next   = velocity_o;
        if (byte_vld) begin
            if (shreg >= 8'hF8) begin
                // real-time bytes are transparent to the message in progress
            end else if (shreg >= 8'hF0) begin
                stat_nine_next = 1'b0;
                accept_next    = 1'b0;
                p_next         = P_IDLE;
            end else if (shreg[7]) begin
                stat_nine_next = (shreg[7:4] == 4'h9);
                len2_next      = !(shreg[7:4] == 4'hC || shreg[7:4] == 4'hD);
                accept_next    = (shreg[7:5] == 3'b100) && (OMNI || shreg[3:0] == CH);
                p_next         = P_D1;
            end else begin
                case (p_state)
                    P_D1: begin
                        note_hold_next = shreg[6:0];
                        if (len2) p_next = P_D2;
                    end
                    P_D2: begin
                        p_next = P_D1;
                        if (accept) begin
                            note_out_next = note_hold;
                            vel_out_next  = shreg[6:0];
                            on_next       = stat_nine && (shreg[6:0] != 7'd0);
                            off_next      = !(stat_nine && (shreg[6:0] != 7'd0));
                        end
                    end
                    default: ;
                endcase
            end
        end
    end
endmodule
